uart_tx_buf: RTL

UART_TX_BUF -- requirements
Module: uart_tx_buf

---
 rtl/uart_pkg.sv | 22 ++
 rtl/uart_fifo_ram.sv | 29 ++
 rtl/uart_tx_buf.sv | 97 +++++++++
 3 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions: byte width, default transmit-buffer depth and baud constants.
package uart_pkg;

    localparam int UART_DATA_W     = 8;
    localparam int UART_FIFO_DEPTH = 16;
    localparam int UART_FIFO_AW    = $clog2(UART_FIFO_DEPTH);

    // Clock cycles per serial bit and the counter width needed to hold that count.
    localparam int UART_BAUD_CNT   = 16;
    localparam int UART_BAUD_CNT_W = $clog2(UART_BAUD_CNT);

    typedef logic [UART_DATA_W-1:0] uart_byte_t;

    // Transfer activity on one clock edge, encoded as {write, read}.
    typedef enum logic [1:0] {
        XFER_NONE = 2'b00,
        XFER_POP  = 2'b01,
        XFER_PUSH = 2'b10,
        XFER_BOTH = 2'b11
    } xfer_e;

endpackage

// File: rtl/uart_fifo_ram.sv
// Byte storage for the UART transmit buffer: DEPTH x 8, one synchronous write port,
// asynchronous read port.
module uart_fifo_ram
    import uart_pkg::*;
#(
    parameter int DEPTH = UART_FIFO_DEPTH,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic                   i_clk,
    input  logic                   i_wr_en,
    input  logic [AW-1:0]          i_wr_addr,
    input  logic [UART_DATA_W-1:0] i_wr_data,
    input  logic [AW-1:0]          i_rd_addr,
    output logic [UART_DATA_W-1:0] o_rd_data
);

    logic [UART_DATA_W-1:0] mem [DEPTH];

    // NOTE: the array has no reset; a slot is never read before it is written, and a
    // reset would prevent mapping onto distributed RAM.
    always_ff @(posedge i_clk) begin
        if (i_wr_en) begin
            mem[i_wr_addr] <= i_wr_data;
        end
    end

    assign o_rd_data = mem[i_rd_addr];

endmodule

// File: rtl/uart_tx_buf.sv
// First-word fall-through byte buffer between a producer and a uart_tx transmitter.
// Owns the pointers, occupancy count and sticky overflow flag; storage is uart_fifo_ram.
module uart_tx_buf
    import uart_pkg::*;
#(
    parameter int DEPTH = UART_FIFO_DEPTH,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic                   i_clk,
    input  logic                   i_rst,
    input  logic                   i_wr_valid,
    input  logic [UART_DATA_W-1:0] i_wr_data,
    output logic                   o_wr_ready,
    input  logic                   i_flush,
    output logic                   o_tx_valid,
    output logic [UART_DATA_W-1:0] o_tx_data,
    input  logic                   i_tx_ready,
    output logic [AW:0]            o_count,
    output logic                   o_overflow
);

    localparam logic [AW:0]   COUNT_FULL = (AW+1)'(DEPTH);
    localparam logic [AW:0]   COUNT_ONE  = (AW+1)'(1);
    localparam logic [AW-1:0] PTR_ONE    = AW'(1);

    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   count;
    logic [AW:0]   count_nxt;
    logic          overflow;
    logic          wr_en;
    logic          rd_en;
    xfer_e         xfer;

    assign o_wr_ready = (count != COUNT_FULL);
    assign o_tx_valid = (count != '0);
    assign o_count    = count;
    assign o_overflow = overflow;

    // Handshakes are qualified by occupancy, so a full buffer refuses even when a
    // read frees a slot on the same edge, and an empty buffer never bypasses.
    assign wr_en = i_wr_valid && o_wr_ready;
    assign rd_en = o_tx_valid && i_tx_ready;
    assign xfer  = xfer_e'({wr_en, rd_en});

    // NOTE: count_nxt is assigned first on every pass so no path leaves it
    // unassigned and no latch is inferred.
    always_comb begin
        count_nxt = count;
        case (xfer)
            XFER_PUSH: count_nxt = count + COUNT_ONE;
            XFER_POP:  count_nxt = count - COUNT_ONE;
            default:   count_nxt = count;
        endcase
    end

    // NOTE: state registers use non-blocking assignments so every register samples
    // the pre-edge values, independent of statement order.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            overflow <= 1'b0;
        end else if (i_flush) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            overflow <= 1'b0;
        end else begin
            if (wr_en) begin
                wr_ptr <= wr_ptr + PTR_ONE;
            end
            if (rd_en) begin
                rd_ptr <= rd_ptr + PTR_ONE;
            end
            count <= count_nxt;
            if (i_wr_valid && !o_wr_ready) begin
                overflow <= 1'b1;
            end
        end
    end

    // A flushed write must not land in storage either.
    uart_fifo_ram #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_ram (
        .i_clk     (i_clk),
        .i_wr_en   (wr_en && !i_flush),
        .i_wr_addr (wr_ptr),
        .i_wr_data (i_wr_data),
        .i_rd_addr (rd_ptr),
        .o_rd_data (o_tx_data)
    );

endmodule
